// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle ticks into fixed-width level pulses.
// Each accepted tick opens a HIGH window of HIGH_LEN cycles, then a forced-low
// GAP of GAP_LEN cycles. A tick that arrives while the window is busy either
// reloads the window (RETRIGGER=1, HIGH only) or is dropped and counted.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous, active-high reset
//   tick       - request pulse, sampled every rising edge
//   level      - stretched pulse, decoded from state (HIGH)
//   busy       - high whenever state is not IDLE
//   overrun    - 1-cycle pulse, the cycle after a tick is dropped
//   drop_count - saturating count of dropped ticks, cleared only by reset
module pulse_stretcher #(
  parameter int unsigned HIGH_LEN  = 4,
  parameter int unsigned GAP_LEN   = 2,
  parameter bit          RETRIGGER = 1'b0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  output logic       level,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHigh = 2'b01,
    StGap  = 2'b10
  } state_e;

  // Reload values are the length minus one, truncated to the counter width.
  localparam logic [CNT_W-1:0] HighReload = CNT_W'(HIGH_LEN - 1);
  localparam logic [CNT_W-1:0] GapReload  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop;
  logic             overrun_q;
  logic [7:0]       drop_count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop    = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StHigh;
          cnt_d   = HighReload;
        end
      end
      StHigh: begin
        if (tick && RETRIGGER) begin
          // Retrigger wins over expiry, even on the last high cycle.
          cnt_d = HighReload;
        end else begin
          drop = tick;
          if (cnt_q == '0) begin
            if (GAP_LEN > 0) begin
              state_d = StGap;
              cnt_d   = GapReload;
            end else begin
              state_d = StIdle;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      StGap: begin
        drop = tick;
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        // Illegal code 2'b11 falls back to IDLE; any tick here is ignored.
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= drop;
      if (drop && (drop_count_q != 8'hFF)) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign level      = (state_q == StHigh);
  assign busy       = (state_q != StIdle);
  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher. Three instances share one tick/reset stream:
// default (4/2, no retrigger), retrigger (4/2), and no-gap (4/0). A timeline
// reference model pushes per-cycle expectations; a negedge monitor checks them.
module tb_pulse_stretcher;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic       level      [3];
  logic       busy       [3];
  logic       overrun    [3];
  logic [7:0] drop_count [3];

  always #5 clock = ~clock;

  pulse_stretcher #(.HIGH_LEN(4), .GAP_LEN(2), .RETRIGGER(1'b0), .CNT_W(8)) u_base (
    .clock(clock), .reset(reset), .tick(tick), .level(level[0]), .busy(busy[0]),
    .overrun(overrun[0]), .drop_count(drop_count[0])
  );
  pulse_stretcher #(.HIGH_LEN(4), .GAP_LEN(2), .RETRIGGER(1'b1), .CNT_W(8)) u_retrig (
    .clock(clock), .reset(reset), .tick(tick), .level(level[1]), .busy(busy[1]),
    .overrun(overrun[1]), .drop_count(drop_count[1])
  );
  pulse_stretcher #(.HIGH_LEN(4), .GAP_LEN(0), .RETRIGGER(1'b0), .CNT_W(8)) u_nogap (
    .clock(clock), .reset(reset), .tick(tick), .level(level[2]), .busy(busy[2]),
    .overrun(overrun[2]), .drop_count(drop_count[2])
  );

  localparam int HL [3] = '{4, 4, 4};
  localparam int GL [3] = '{2, 2, 0};
  localparam int RT [3] = '{0, 1, 0};

  typedef struct {
    int             cyc;
    logic [2:0]     lv;
    logic [2:0]     bz;
    logic [2:0]     ov;
    logic [2:0][7:0] dc;
  } exp_t;

  exp_t q[$];
  int   cur   = 0;
  int   total = 0;
  int   bad   = 0;

  // Model: each instance remembers the last cycle its level is high and the
  // last cycle it is busy; the state in any cycle follows from those times.
  int hi_until  [3] = '{-1, -1, -1};
  int gap_until [3] = '{-1, -1, -1};
  int drops     [3] = '{0, 0, 0};

  // One clock cycle: drive inputs for cycle cur, predict outputs of cur+1.
  task automatic step(input logic t, input logic r);
    exp_t e;
    bit   in_high, in_gap, ov;
    @(posedge clock);
    cur++;
    #1;
    tick  = t;
    reset = r;
    e.cyc = cur + 1;
    for (int i = 0; i < 3; i++) begin
      ov = 1'b0;
      if (r) begin
        hi_until[i]  = -1;
        gap_until[i] = -1;
        drops[i]     = 0;
      end else if (t) begin
        in_high = (cur <= hi_until[i]);
        in_gap  = !in_high && (cur <= gap_until[i]);
        if ((!in_high && !in_gap) || (in_high && RT[i] == 1)) begin
          hi_until[i]  = cur + HL[i];
          gap_until[i] = cur + HL[i] + GL[i];
        end else begin
          ov       = 1'b1;
          drops[i] = (drops[i] < 255) ? drops[i] + 1 : 255;
        end
      end
      e.lv[i] = (cur + 1 <= hi_until[i]);
      e.bz[i] = (cur + 1 <= gap_until[i]);
      e.ov[i] = ov;
      e.dc[i] = 8'(drops[i]);
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cur) begin
      e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (level[i] !== e.lv[i] || busy[i] !== e.bz[i] || overrun[i] !== e.ov[i] ||
            drop_count[i] !== e.dc[i][7:0]) begin
          bad++;
          $display("FAIL dut%0d cycle %0d: got level=%b busy=%b overrun=%b drop_count=%0d, want level=%b busy=%b overrun=%b drop_count=%0d",
                   i, cur, level[i], busy[i], overrun[i], drop_count[i],
                   e.lv[i], e.bz[i], e.ov[i], e.dc[i][7:0]);
        end
      end
    end
  end

  initial begin
    // Reset, then idle.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    idle(5);
    // Single tick.
    step(1'b1, 1'b0); idle(10);
    // Back-to-back ticks.
    step(1'b1, 1'b0); step(1'b1, 1'b0); idle(10);
    // Tick, then tick three cycles later (retrigger on one instance).
    step(1'b1, 1'b0); idle(2); step(1'b1, 1'b0); idle(12);
    // Tick, tick in gap, tick once idle.
    step(1'b1, 1'b0); idle(4); step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(10);
    // Reset during HIGH.
    step(1'b1, 1'b0); idle(1); step(1'b0, 1'b1); idle(8);
    // Reset during GAP, with a coincident tick that must be ignored.
    step(1'b1, 1'b0); idle(4); step(1'b1, 1'b1); idle(8);
    // Tick held high long enough to saturate the drop counter.
    for (int k = 0; k < 2000; k++) step(1'b1, 1'b0);
    idle(10);
    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    // Let the monitor consume the last expectation.
    @(posedge clock);
    cur++;
    @(negedge clock);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
